ib_dnu_hd_lut_pp: RTL and testbench
===================================

# ib_dnu_hd_lut_pp

Parametrised multi-lane decision-node (DNU) hard-decision stage with a ping-pong iteration-update LUT. Each lane forms a symmetric-LUT address from its `t` message and its last C2V message, honouring a per-lane transpose enable. The lanes read one active LUT page while the host loads the next iteration's table into the shadow page. A guarded swap handshake flips the pages without disturbing samples already in flight. It is the successor to the fixed 4-reader DNU f0 stage and sits between the VNU/C2V pipeline and the hard-decision collector.

## Interface
Parameters:
- QUAN_SIZE, 4, message width; LUT entries per page = 2^(2*QUAN_SIZE)
- LANE_NUM, 4, number of parallel DNU lanes (1..16)
- WR_WIDTH, 8, LUT bits per write word (power of 2, ≤ 2^(2*QUAN_SIZE))
- Derived: WORD_NUM = 2^(2*QUAN_SIZE)/WR_WIDTH; WR_ADDR_W = 2*QUAN_SIZE − log2(WR_WIDTH), minimum 1

Ports:
- read_clk  in  1  sole clock. All logic is rising-edge.
- rstn  in  1  asynchronous reset, active low
- in_valid  in  1  lane inputs valid this cycle
- t_in  in  LANE_NUM*QUAN_SIZE  per-lane t message; lane i = [i*QUAN_SIZE +: QUAN_SIZE]
- c2v_in  in  LANE_NUM*QUAN_SIZE  per-lane last C2V message
- tran_en  in  LANE_NUM  per-lane transpose enable
- hd_out  out  LANE_NUM  per-lane hard decision
- out_valid  out  1  hd_out valid
- out_page  out  1  page used for the current hd_out
- wr_en  in  1  shadow-page write strobe
- wr_addr  in  WR_ADDR_W  shadow word address
- wr_data  in  WR_WIDTH  LUT word
- shadow_full  out  1  shadow page loaded; swap permitted
- swap_req  in  1  level request to make the shadow page active
- swap_ack  out  1  one-cycle pulse confirming the swap
- active_page  out  1  page currently read by the lanes

## Operation
- **Address formation** per lane: `e = tran_en ? {c2v, t} : {t, c2v}`. The first field is the high QUAN_SIZE bits.
- **LUT storage**: two pages of 2^(2*QUAN_SIZE) bits each. Entry `e` lives in word `e >> log2(WR_WIDTH)` at bit `e mod WR_WIDTH`, i.e. `wr_data[e mod WR_WIDTH]`. LUT contents are not reset.
- **Writes** always go to page `~active_page_next`, the shadow page after any same-cycle swap.
- **shadow_full** is set by an accepted write to address WORD_NUM−1. The host therefore loads in ascending order. The flag is cleared by a swap and is otherwise sticky.
- **Swap**: executes at any edge where `swap_req=1 && shadow_full=1`. At that edge:
  - active_page toggles
  - shadow_full clears, unless the same-edge write hits WORD_NUM−1, in which case it is set for the new shadow page
  - swap_ack is high for the next cycle only
- **Pending request**: if swap_req is high while shadow_full=0, the request waits. The host holds swap_req until it sees swap_ack, then drops it. If swap_req is still high in the ack cycle, that is a new request.
- **Pipeline**:
  - Stage 0 registers in_valid, the lane addresses and the page tag (the active_page value before the edge).
  - Stage 1 performs the LUT read using the captured tag and registers hd_out, out_valid and out_page.
  - In-flight samples complete on the page they entered with, even across a swap.
- **Read/write collision**: if stage 1 reads an entry that is written at the same edge, it returns the old data.
- **Invalid cycles**: hd_out is 0 whenever out_valid=0.

## Timing
- Reset values:
  - hd_out = 0, out_valid = 0, out_page = 0
  - active_page = 0, shadow_full = 0, swap_ack = 0
  - both pipeline valid bits = 0
- Latency: a sample presented in cycle n appears on hd_out / out_valid in cycle n+2. Throughput is one sample set per cycle and there is no backpressure.
- Back-to-back swaps are impossible: the second swap needs a full reload, i.e. a write to WORD_NUM−1 after the first swap edge.
- Reset asserted mid-operation: in-flight samples are lost and the page state returns to page 0. LUT memory keeps its contents.
- Writes with wr_addr ≥ WORD_NUM (possible only when WR_ADDR_W is padded) are ignored and do not set shadow_full.

## Test plan
- **Load and swap**: after reset, write page 1 with entry `e` = parity(e), words 0..WORD_NUM−1, then pulse swap_req.
  - Expected: swap_ack 1 cycle after the swap edge, active_page=1.
  - Then lane0 t=3, c2v=5, tran_en=0 (e=0x35) → hd_out[0]=0 two cycles later, with out_page=1.
- **Transpose**: load page with `hd = (e[7:4] > e[3:0])`. Apply lane1 t=9, c2v=2 with tran_en=0, then the same inputs with tran_en=1.
  - Expected: hd_out[1]=1, then 0.
- **Early swap request**: assert swap_req with shadow_full=0.
  - Expected: no ack and active_page unchanged.
  - Finish the load with a write to WORD_NUM−1 → swap at the following edge, ack one cycle later.
- **Swap with samples in flight**: stream in_valid=1 continuously while a swap executes between page 0 (all 0) and page 1 (all 1).
  - Expected: outputs switch from 0 to 1 exactly at the sample boundary given by each sample's entry cycle, with out_page tracking that boundary. No sample is dropped.
- **Same-cycle collision**: write entry 0x00 to 1 in the same cycle stage 1 reads entry 0x00 on the active page.
  - Expected: hd_out=old value, and the next read returns 1.
- **Mid-stream reset**: pulse rstn low while out_valid=1.
  - Expected: all outputs are 0 immediately (asynchronous), active_page=0 and shadow_full=0.
  - After reset is released, a read of page 0 returns the previously loaded contents.

Source files
------------

// File: rtl/ib_dnu_hd_lut_pp.sv
// ---------------------------------------------------------------------------
// ib_dnu_hd_lut_pp
//
// Multi-lane decision-node hard-decision stage with a ping-pong LUT.
// Every lane builds a symmetric LUT address from its t message and its last
// C2V message, optionally transposed. The lanes read the active LUT page
// while the host fills the shadow page. A guarded swap handshake exchanges
// the pages. Each sample carries the page tag it was captured with, so
// samples already in the pipeline finish on their original page.
//
// Parameters
//   QUAN_SIZE  message width; each page holds 2^(2*QUAN_SIZE) one-bit entries
//   LANE_NUM   number of parallel lanes (1..16)
//   WR_WIDTH   LUT bits per host write word (power of two)
//
// Ports
//   read_clk     sole clock, rising edge
//   rstn         asynchronous reset, active low
//   in_valid     lane inputs valid this cycle
//   t_in         per-lane t message, lane i at [i*QUAN_SIZE +: QUAN_SIZE]
//   c2v_in       per-lane last C2V message, same packing as t_in
//   tran_en      per-lane transpose enable
//   hd_out       per-lane hard decision (0 while out_valid is low)
//   out_valid    hd_out valid
//   out_page     page that produced the current hd_out
//   wr_en        shadow-page write strobe
//   wr_addr      shadow word address
//   wr_data      LUT word; bit k holds entry (wr_addr*WR_WIDTH + k)
//   shadow_full  shadow page completely loaded, swap permitted
//   swap_req     level request to make the shadow page active
//   swap_ack     one-cycle pulse following an executed swap
//   active_page  page currently read by newly captured samples
// ---------------------------------------------------------------------------
module ib_dnu_hd_lut_pp #(
    parameter  int QUAN_SIZE = 4,
    parameter  int LANE_NUM  = 4,
    parameter  int WR_WIDTH  = 8,
    localparam int ENTRY_W   = 2 * QUAN_SIZE,
    localparam int ENTRY_NUM = 1 << ENTRY_W,
    localparam int WORD_NUM  = ENTRY_NUM / WR_WIDTH,
    localparam int WR_SHIFT  = $clog2(WR_WIDTH),
    localparam int WR_ADDR_W = ((ENTRY_W - WR_SHIFT) < 1) ? 1 : (ENTRY_W - WR_SHIFT)
) (
    input  logic                          read_clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    input  logic [LANE_NUM*QUAN_SIZE-1:0] t_in,
    input  logic [LANE_NUM*QUAN_SIZE-1:0] c2v_in,
    input  logic [LANE_NUM-1:0]           tran_en,
    output logic [LANE_NUM-1:0]           hd_out,
    output logic                          out_valid,
    output logic                          out_page,
    input  logic                          wr_en,
    input  logic [WR_ADDR_W-1:0]          wr_addr,
    input  logic [WR_WIDTH-1:0]           wr_data,
    output logic                          shadow_full,
    input  logic                          swap_req,
    output logic                          swap_ack,
    output logic                          active_page
);

    // -----------------------------------------------------------------------
    // Page control
    // -----------------------------------------------------------------------
    typedef enum logic {
        SH_LOADING,
        SH_FULL
    } shadow_state_t;

    shadow_state_t shadow_state;
    shadow_state_t shadow_state_next;

    logic swap_fire;
    logic last_write;
    logic addr_in_range;
    logic active_page_next;
    logic write_page;

    // Padded address bits can reach past the last word; such writes are dropped.
    assign addr_in_range = ({1'b0, wr_addr} < (WR_ADDR_W + 1)'(WORD_NUM));

    always_comb begin
        swap_fire         = 1'b0;
        last_write        = 1'b0;
        active_page_next  = active_page;
        shadow_state_next = shadow_state;

        swap_fire        = swap_req && (shadow_state == SH_FULL);
        last_write       = wr_en && (wr_addr == WR_ADDR_W'(WORD_NUM - 1));
        active_page_next = active_page ^ swap_fire;

        // A final-word write on the swap edge belongs to the new shadow page,
        // so it wins over the clear caused by the swap.
        if (last_write) begin
            shadow_state_next = SH_FULL;
        end else if (swap_fire) begin
            shadow_state_next = SH_LOADING;
        end
    end

    // Writes target the page that will be shadow after this edge.
    assign write_page  = ~active_page_next;
    assign shadow_full = (shadow_state == SH_FULL);

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            shadow_state <= SH_LOADING;
            active_page  <= 1'b0;
            swap_ack     <= 1'b0;
        end else begin
            shadow_state <= shadow_state_next;
            active_page  <= active_page_next;
            swap_ack     <= swap_fire;
        end
    end

    // -----------------------------------------------------------------------
    // LUT storage: two flat pages, one bit per entry, never reset
    // -----------------------------------------------------------------------
    logic [ENTRY_NUM-1:0] lut_mem [2];
    logic [ENTRY_W-1:0]   wr_base;

    assign wr_base = ENTRY_W'(wr_addr) << WR_SHIFT;

    always_ff @(posedge read_clk) begin
        if (wr_en && addr_in_range) begin
            lut_mem[write_page][wr_base +: WR_WIDTH] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Address formation
    // -----------------------------------------------------------------------
    logic [LANE_NUM-1:0][ENTRY_W-1:0] lane_addr;

    always_comb begin
        lane_addr = '0;
        for (int unsigned i = 0; i < LANE_NUM; i++) begin
            if (tran_en[i]) begin
                lane_addr[i] = {c2v_in[i*QUAN_SIZE +: QUAN_SIZE], t_in[i*QUAN_SIZE +: QUAN_SIZE]};
            end else begin
                lane_addr[i] = {t_in[i*QUAN_SIZE +: QUAN_SIZE], c2v_in[i*QUAN_SIZE +: QUAN_SIZE]};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 0: capture valid, addresses and the page tag
    // -----------------------------------------------------------------------
    logic                             s0_valid;
    logic                             s0_page;
    logic [LANE_NUM-1:0][ENTRY_W-1:0] s0_addr;

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            s0_valid <= 1'b0;
            s0_page  <= 1'b0;
            s0_addr  <= '0;
        end else begin
            s0_valid <= in_valid;
            s0_page  <= active_page;
            s0_addr  <= lane_addr;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: LUT read on the tagged page
    // -----------------------------------------------------------------------
    // The read samples memory before this edge's write lands, so a colliding
    // write is seen only by later samples.
    logic [LANE_NUM-1:0] rd_bits;

    always_comb begin
        rd_bits = '0;
        for (int unsigned i = 0; i < LANE_NUM; i++) begin
            rd_bits[i] = lut_mem[s0_page][s0_addr[i]];
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_page  <= 1'b0;
            hd_out    <= '0;
        end else begin
            out_valid <= s0_valid;
            hd_out    <= s0_valid ? rd_bits : '0;
            if (s0_valid) begin
                out_page <= s0_page;
            end
        end
    end

endmodule

// File: tb/tb_ib_dnu_hd_lut_pp.sv
module tb_ib_dnu_hd_lut_pp;

    localparam int K_PAR  = 0;
    localparam int K_GT   = 1;
    localparam int K_ZERO = 2;
    localparam int K_ONE  = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] t_in = '0;
    logic [15:0] c2v_in = '0;
    logic [3:0]  tran_en = '0;
    logic [3:0]  hd_out;
    logic        out_valid;
    logic        out_page;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        shadow_full;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        active_page;

    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    ib_dnu_hd_lut_pp #(
        .QUAN_SIZE(4),
        .LANE_NUM (4),
        .WR_WIDTH (8)
    ) dut (
        .read_clk   (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .t_in       (t_in),
        .c2v_in     (c2v_in),
        .tran_en    (tran_en),
        .hd_out     (hd_out),
        .out_valid  (out_valid),
        .out_page   (out_page),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .shadow_full(shadow_full),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .active_page(active_page)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: page contents as plain bit arrays, samples as
    // records carrying the page they were captured on.
    // ------------------------------------------------------------------
    bit   m_lut [2][256];
    logic m_active = 1'b0;
    logic m_full = 1'b0;
    logic m_ack = 1'b0;
    logic m_valid = 1'b0;
    logic [3:0] m_hd = '0;
    logic m_page = 1'b0;
    logic p_valid = 1'b0;
    logic p_page = 1'b0;
    int   p_addr [4];
    logic m_sw;
    logic m_na;
    int   m_wp;
    int   m_tv;
    int   m_cv;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active = 1'b0;
            m_full   = 1'b0;
            m_ack    = 1'b0;
            m_valid  = 1'b0;
            m_hd     = '0;
            m_page   = 1'b0;
            p_valid  = 1'b0;
        end else begin
            m_valid = p_valid;
            for (int l = 0; l < 4; l++) begin
                m_hd[l] = p_valid ? m_lut[int'(p_page)][p_addr[l]] : 1'b0;
            end
            if (p_valid) m_page = p_page;

            p_valid = in_valid;
            p_page  = m_active;
            for (int l = 0; l < 4; l++) begin
                m_tv = int'(t_in[l*4 +: 4]);
                m_cv = int'(c2v_in[l*4 +: 4]);
                p_addr[l] = tran_en[l] ? (m_cv * 16 + m_tv) : (m_tv * 16 + m_cv);
            end

            m_sw = swap_req && m_full;
            m_na = m_active ^ m_sw;
            m_wp = m_na ? 0 : 1;
            if (wr_en && int'(wr_addr) < 32) begin
                for (int b = 0; b < 8; b++) begin
                    m_lut[m_wp][int'(wr_addr) * 8 + b] = wr_data[b];
                end
            end
            if (wr_en && int'(wr_addr) == 31) m_full = 1'b1;
            else if (m_sw) m_full = 1'b0;
            m_ack    = m_sw;
            m_active = m_na;
        end
    end

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            chk("mon_out_valid", 32'(out_valid), 32'(m_valid));
            chk("mon_hd_out", 32'(hd_out), 32'(m_hd));
            if (m_valid) chk("mon_out_page", 32'(out_page), 32'(m_page));
            chk("mon_active_page", 32'(active_page), 32'(m_active));
            chk("mon_shadow_full", 32'(shadow_full), 32'(m_full));
            chk("mon_swap_ack", 32'(swap_ack), 32'(m_ack));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] word_of(input int kind, input int w);
        logic [7:0] d;
        logic [7:0] ev;
        d = '0;
        for (int b = 0; b < 8; b++) begin
            ev = 8'(w * 8 + b);
            case (kind)
                K_PAR:   d[b] = ^ev;
                K_GT:    d[b] = (ev[7:4] > ev[3:0]);
                K_ZERO:  d[b] = 1'b0;
                default: d[b] = 1'b1;
            endcase
        end
        return d;
    endfunction

    task automatic load_words(input int kind, input int first, input int last_w);
        for (int w = first; w <= last_w; w++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 5'(w);
            wr_data = word_of(kind, w);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_swap(input string nm, input logic exp_active);
        int seen;
        seen = -1;
        @(negedge clk);
        swap_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (swap_ack) begin
                seen = k;
                break;
            end
        end
        @(negedge clk);
        swap_req = 1'b0;
        chk({nm, "_ack_latency"}, 32'(seen), 32'd0);
        chk({nm, "_active"}, 32'(active_page), 32'(exp_active));
    endtask

    task automatic sample(input logic [15:0] t, input logic [15:0] c, input logic [3:0] tr,
                          input logic [3:0] exp_hd, input logic exp_pg, input string nm);
        @(negedge clk);
        in_valid = 1'b1;
        t_in     = t;
        c2v_in   = c;
        tran_en  = tr;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_hd"}, 32'(hd_out), 32'(exp_hd));
        chk({nm, "_page"}, 32'(out_page), 32'(exp_pg));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int nvalid;

    initial begin
        #2 rstn = 1'b0;
        #1 mon_en = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk("reset_active", 32'(active_page), 32'd0);
        chk("reset_full", 32'(shadow_full), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_hd", 32'(hd_out), 32'd0);
        chk("reset_ack", 32'(swap_ack), 32'd0);

        // Load page 1 with parity, swap, read e=0x35 (even) and e=0x10 (odd)
        load_words(K_PAR, 0, 31);
        chk("par_full", 32'(shadow_full), 32'd1);
        do_swap("swap1", 1'b1);
        sample(16'h0013, 16'h0005, 4'b0000, 4'b0010, 1'b1, "parity");

        // Page 0 gets hd = e[7:4] > e[3:0]; check transpose
        load_words(K_GT, 0, 31);
        do_swap("swap2", 1'b0);
        sample(16'h0090, 16'h0020, 4'b0000, 4'b0010, 1'b0, "tran_off");
        sample(16'h0290, 16'h0920, 4'b0110, 4'b0100, 1'b0, "tran_on");

        // Early request: no swap until the final word lands
        load_words(K_ONE, 0, 30);
        chk("early_full", 32'(shadow_full), 32'd0);
        swap_req = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("early_no_ack", 32'(swap_ack), 32'd0);
            chk("early_active", 32'(active_page), 32'd0);
        end
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = 8'hFF;
        @(posedge clk);
        #1;
        chk("early_full_set", 32'(shadow_full), 32'd1);
        chk("early_ack_wait", 32'(swap_ack), 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        chk("early_ack", 32'(swap_ack), 32'd1);
        chk("early_swapped", 32'(active_page), 32'd1);
        @(negedge clk);
        swap_req = 1'b0;
        @(posedge clk);
        #1;
        chk("early_ack_pulse", 32'(swap_ack), 32'd0);

        // Page 0 all zero active, page 1 all one loaded; swap mid-stream
        load_words(K_ZERO, 0, 31);
        do_swap("swap3", 1'b0);
        load_words(K_ONE, 0, 31);
        nvalid = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j == 5) chk("stream_ack", 32'(swap_ack), 32'd1);
            in_valid = (j < 10);
            t_in     = 16'($urandom);
            c2v_in   = 16'($urandom);
            tran_en  = 4'($urandom);
            if (j == 4) swap_req = 1'b1;
            if (j == 5) swap_req = 1'b0;
            @(posedge clk);
            #1;
            if (j >= 1) begin
                nvalid += int'(out_valid);
                if (j - 1 < 10) begin
                    chk("stream_hd", 32'(hd_out), (j - 1 <= 4) ? 32'h0 : 32'hF);
                    chk("stream_page", 32'(out_page), (j - 1 <= 4) ? 32'd0 : 32'd1);
                end else begin
                    chk("stream_tail_hd", 32'(hd_out), 32'h0);
                end
            end
        end
        chk("stream_count", 32'(nvalid), 32'd10);

        // Collision: a stage-1 read of page 0 entry 0 meets a write to it
        load_words(K_ZERO, 0, 31);
        do_swap("swap4", 1'b0);
        load_words(K_ONE, 0, 31);
        @(negedge clk);
        in_valid = 1'b1;
        t_in     = '0;
        c2v_in   = '0;
        tran_en  = '0;
        @(negedge clk);
        swap_req = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 8'h01;
        @(posedge clk);
        #1;
        chk("coll_old_hd", 32'(hd_out), 32'h0);
        chk("coll_old_page", 32'(out_page), 32'd0);
        chk("coll_swap", 32'(active_page), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wr_en    = 1'b0;
        swap_req = 1'b0;
        @(posedge clk);
        #1;
        chk("coll_new_hd", 32'(hd_out), 32'hF);
        chk("coll_new_page", 32'(out_page), 32'd0);

        // Mid-stream asynchronous reset
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            t_in     = 16'($urandom);
            c2v_in   = 16'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_hd", 32'(hd_out), 32'd0);
        chk("arst_page", 32'(out_page), 32'd0);
        chk("arst_active", 32'(active_page), 32'd0);
        chk("arst_full", 32'(shadow_full), 32'd0);
        chk("arst_ack", 32'(swap_ack), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        sample(16'h0000, 16'h7010, 4'b0000, 4'b0101, 1'b0, "post_reset");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
